// File: rtl/jzjpcc_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches to a 1-cycle SRAM and
// buffers responses in a FIFO for decode; redirects flush the queue and refetch.
module jzjpcc_prefetch_queue #(
  parameter int          PC_MAX_B    = 15,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h00000000
) (
  input  logic                               clock,
  input  logic                               reset,
  output logic [PC_MAX_B:2]                  instructionAddressToLatch,
  output logic                               imemRequest,
  input  logic [31:0]                        instruction_fetch,
  output logic [31:0]                        instruction_decode,
  output logic [PC_MAX_B:2]                  currentPC_decode,
  output logic                               decodeValid,
  input  logic                               stall_fetch,
  input  logic                               pcCTWriteEnable,
  input  logic [PC_MAX_B:2]                  controlTransferNewPC,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queueCount
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH+1);
  localparam int OW = CW + 1;

  typedef struct packed {
    logic [PC_MAX_B:2] pc;
    logic [31:0]       instr;
  } entry_t;

  entry_t            q [QUEUE_DEPTH];
  logic [AW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic              in_flight;
  logic [PC_MAX_B:2] fetch_pc, req_pc;
  logic              pop, push;
  logic [OW-1:0]     occ;

  assign decodeValid = (count != '0);
  assign pop         = decodeValid && !stall_fetch && !pcCTWriteEnable;
  // A redirect drops whatever response is returning this cycle.
  assign push        = in_flight && !pcCTWriteEnable;
  // Occupancy including the outstanding response; pop implies count >= 1, so no underflow.
  assign occ         = {1'b0, count} + OW'(in_flight) - OW'(pop);

  assign imemRequest = !reset && (pcCTWriteEnable || (occ < OW'(QUEUE_DEPTH)));
  assign instructionAddressToLatch = pcCTWriteEnable ? controlTransferNewPC : fetch_pc;

  assign instruction_decode = decodeValid ? q[head].instr : 32'h00000013;
  assign currentPC_decode   = decodeValid ? q[head].pc    : '0;
  assign queueCount         = count;

  always_ff @(posedge clock) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      in_flight <= 1'b0;
      req_pc    <= '0;
      fetch_pc  <= RESET_PC[PC_MAX_B:2];
    end else if (pcCTWriteEnable) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      in_flight <= 1'b1;
      req_pc    <= controlTransferNewPC;
      fetch_pc  <= controlTransferNewPC + 1'b1;
    end else begin
      in_flight <= imemRequest;
      if (imemRequest) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 1'b1;
      end
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clock) begin
    if (!reset && push) q[tail] <= '{pc: req_pc, instr: instruction_fetch};
  end
endmodule

// File: tb/tb_jzjpcc_prefetch_queue.sv
// Scoreboard bench for jzjpcc_prefetch_queue: directed stall/redirect/reset scenarios
// plus a second instance checking PC wrap from the top of the address space.
module tb_jzjpcc_prefetch_queue;
  localparam int PCMB = 15;
  localparam int PCW  = PCMB - 1;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            stall = 1'b0, redir = 1'b0;
  logic [PCW-1:0]  target = '0;
  logic            zero_bit = 1'b0;
  logic [PCW-1:0]  zero_pc  = '0;

  logic [PCW-1:0]  addr0, pc0, addr1, pc1;
  logic            req0, valid0, req1, valid1;
  logic [31:0]     fetch0 = '0, fetch1 = '0, instr0, instr1;
  logic [2:0]      count0, count1;

  int n_chk = 0, n_fail = 0, n_pops = 0;
  logic [PCW-1:0] exp_q[$];

  always #5 clock = ~clock;

  jzjpcc_prefetch_queue #(.PC_MAX_B(PCMB), .QUEUE_DEPTH(4), .RESET_PC(32'h0)) u0 (
    .clock(clock), .reset(reset),
    .instructionAddressToLatch(addr0), .imemRequest(req0),
    .instruction_fetch(fetch0), .instruction_decode(instr0),
    .currentPC_decode(pc0), .decodeValid(valid0),
    .stall_fetch(stall), .pcCTWriteEnable(redir),
    .controlTransferNewPC(target), .queueCount(count0));

  jzjpcc_prefetch_queue #(.PC_MAX_B(PCMB), .QUEUE_DEPTH(4), .RESET_PC(32'h0000FFFC)) u1 (
    .clock(clock), .reset(reset),
    .instructionAddressToLatch(addr1), .imemRequest(req1),
    .instruction_fetch(fetch1), .instruction_decode(instr1),
    .currentPC_decode(pc1), .decodeValid(valid1),
    .stall_fetch(zero_bit), .pcCTWriteEnable(zero_bit),
    .controlTransferNewPC(zero_pc), .queueCount(count1));

  // Instruction SRAM: word at address a holds {16'hC0DE, 2'b00, a}.
  function automatic logic [31:0] mem_word(input logic [PCW-1:0] a);
    return {16'hC0DE, 2'b00, a};
  endfunction

  always @(posedge clock) begin
    if (req0) fetch0 <= mem_word(addr0);
    if (req1) fetch1 <= mem_word(addr1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic restart(input logic [PCW-1:0] base);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(base + PCW'(i));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every pop must deliver the next expected PC and its memory word.
  always @(negedge clock) begin
    if (!reset && valid0 && !stall && !redir) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty: got pc %h expected none", pc0);
      end else begin
        logic [PCW-1:0] e;
        e = exp_q.pop_front();
        check("pop_pc", 32'(pc0), 32'(e));
        check("pop_instr", instr0, mem_word(e));
        n_pops++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_instr", instr0, 32'h00000013);
    check("rst_pc", 32'(pc0), 32'd0);
    check("rst_count", 32'(count0), 32'd0);
    check("rst_req", 32'(req0), 32'd0);
    check("rst_valid_u1", 32'(valid1), 32'd0);

    // Release: sequential fetch from RESET_PC, one per cycle.
    restart(14'h0000);
    reset = 1'b0;
    #1;
    check("c0_addr", 32'(addr0), 32'h0);
    check("c0_req", 32'(req0), 32'd1);
    check("c0_addr_u1", 32'(addr1), 32'h3FFF);
    check("c0_valid", 32'(valid0), 32'd0);
    step(); #1;
    check("c1_addr", 32'(addr0), 32'h1);
    check("c1_valid", 32'(valid0), 32'd0);
    check("c1_addr_u1", 32'(addr1), 32'h0);
    step(); #1;
    check("c2_valid", 32'(valid0), 32'd1);
    check("c2_count", 32'(count0), 32'd1);
    check("c2_addr", 32'(addr0), 32'h2);
    check("c2_pc_u1", 32'(pc1), 32'h3FFF);
    step(); #1;
    check("c3_pc_u1", 32'(pc1), 32'h0);
    check("c3_count", 32'(count0), 32'd1);
    repeat (3) step();

    // Stall six cycles: queue fills to 4 and requests stop.
    step(); stall = 1'b1; #1;
    check("s0_req", 32'(req0), 32'd1);
    step(); #1;
    check("s1_count", 32'(count0), 32'd2);
    step(); #1;
    check("s2_count", 32'(count0), 32'd3);
    check("s2_req", 32'(req0), 32'd0);
    step(); #1;
    check("s3_count", 32'(count0), 32'd4);
    step(); #1;
    step(); #1;
    check("s5_count", 32'(count0), 32'd4);
    check("s5_req", 32'(req0), 32'd0);
    step(); stall = 1'b0; #1;
    check("s6_req", 32'(req0), 32'd1);
    repeat (4) step();

    // Redirect with 3 entries queued.
    step(); redir = 1'b1; target = 14'h040; restart(14'h040); #1;
    check("rd1_count_before", 32'(count0), 32'd3);
    check("rd1_addr", 32'(addr0), 32'h040);
    check("rd1_req", 32'(req0), 32'd1);
    step(); redir = 1'b0; #1;
    check("rd1_count_after", 32'(count0), 32'd0);
    check("rd1_gap_valid", 32'(valid0), 32'd0);
    check("rd1_gap_instr", instr0, 32'h00000013);
    check("rd1_next_addr", 32'(addr0), 32'h041);
    step(); #1;
    check("rd1_tgt_valid", 32'(valid0), 32'd1);
    check("rd1_tgt_pc", 32'(pc0), 32'h040);
    step(); #1;
    check("rd1_tgt1_pc", 32'(pc0), 32'h041);

    // Fill the queue under stall, then redirect while still stalled.
    step(); stall = 1'b1;
    repeat (5) step();
    #1;
    check("full_count", 32'(count0), 32'd4);
    check("full_req", 32'(req0), 32'd0);
    step(); redir = 1'b1; target = 14'h040; restart(14'h040); #1;
    check("rd2_addr", 32'(addr0), 32'h040);
    check("rd2_req", 32'(req0), 32'd1);
    step(); redir = 1'b0; stall = 1'b0; #1;
    check("rd2_count_after", 32'(count0), 32'd0);
    check("rd2_gap_valid", 32'(valid0), 32'd0);
    step(); #1;
    check("rd2_tgt_pc", 32'(pc0), 32'h040);
    repeat (3) step();

    // Reset mid-operation with 2 queued and one in flight.
    step(); stall = 1'b1; #1;
    check("mr_count_a", 32'(count0), 32'd1);
    step(); reset = 1'b1; exp_q.delete(); #1;
    check("mr_count_b", 32'(count0), 32'd2);
    check("mr_req_in_reset", 32'(req0), 32'd0);
    step(); #1;
    check("mr_valid", 32'(valid0), 32'd0);
    check("mr_instr", instr0, 32'h00000013);
    check("mr_pc", 32'(pc0), 32'd0);
    check("mr_count", 32'(count0), 32'd0);
    stall = 1'b0; restart(14'h0000); reset = 1'b0; #1;
    check("mr_restart_addr", 32'(addr0), 32'h0);
    check("mr_restart_req", 32'(req0), 32'd1);
    step(); #1;
    check("mr_c1_valid", 32'(valid0), 32'd0);
    step(); #1;
    check("mr_c2_valid", 32'(valid0), 32'd1);
    check("mr_c2_pc", 32'(pc0), 32'h0);
    repeat (5) step();

    @(posedge clock); #1;
    check("pop_count_min", 32'(n_pops >= 18), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jzjpcc_prefetch_queue.md
JZJPCC_PREFETCH_QUEUE -- requirements
Module: jzjpcc_prefetch_queue

Interface
REQ-001 Parameter PC_MAX_B, default 15, MSB of the byte PC; PCs are carried as word addresses [PC_MAX_B:2].
REQ-002 Parameter QUEUE_DEPTH, default 4, number of buffered instructions; SHALL be a power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h00000000, byte address of the first fetch; only bits [PC_MAX_B:2] are used.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clock  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 instructionAddressToLatch  out  [PC_MAX_B:2]  word address presented to instruction SRAM this cycle.
REQ-008 imemRequest  out  1  address is a real request; its data returns on instruction_fetch the next cycle.
REQ-009 instruction_fetch  in  32  SRAM read data, big endian, valid the cycle after a request.
REQ-010 instruction_decode  out  32  head instruction, or 32'h00000013 (nop) when queue empty.
REQ-011 currentPC_decode  out  [PC_MAX_B:2]  PC of head instruction; 0 when queue empty.
REQ-012 decodeValid  out  1  head entry present.
REQ-013 stall_fetch  in  1  decode not consuming; head is held.
REQ-014 pcCTWriteEnable  in  1  control-transfer redirect from decode.
REQ-015 controlTransferNewPC  in  [PC_MAX_B:2]  redirect target.
REQ-016 queueCount  out  $clog2(QUEUE_DEPTH+1)  current occupancy.

Function
REQ-017 Pop SHALL occur on a rising edge when decodeValid=1, stall_fetch=0 and pcCTWriteEnable=0.
REQ-018 imemRequest SHALL be 1 iff reset=0 and (queueCount + inFlight - pop) < QUEUE_DEPTH, or pcCTWriteEnable=1; inFlight is the internal 1-bit outstanding-request flag.
REQ-019 Without redirect, instructionAddressToLatch SHALL equal fetchPC; fetchPC increments by 1 on each issued request, wrapping modulo 2^(PC_MAX_B-1).
REQ-020 A response SHALL be pushed, with the PC of its request, at the tail on the edge ending the cycle after the request; it is visible at the outputs the cycle after the push (no bypass).
REQ-021 Push and pop in the same cycle SHALL leave queueCount unchanged; the queue SHALL never overflow or underflow.
REQ-022 Redirect SHALL have priority over stall_fetch and pop: in that cycle, instructionAddressToLatch = controlTransferNewPC with imemRequest=1; the queue empties; any response arriving that cycle is discarded; fetchPC becomes target+1.
REQ-023 Redirect latency: target data visible at decode outputs 2 cycles after the redirect cycle; decodeValid=0 in between.
REQ-024 Back-to-back redirects SHALL each discard the previous in-flight response; only the last target is fetched.
REQ-025 Steady state with stall_fetch=0 SHALL sustain one instruction per cycle for any legal QUEUE_DEPTH.
REQ-026 Order SHALL be strict FIFO; entries SHALL never be duplicated or dropped except by redirect or reset.

Reset
REQ-027 While reset=1: queue empty, inFlight=0, imemRequest=0, decodeValid=0, instruction_decode=32'h00000013, currentPC_decode=0, queueCount=0, fetchPC=RESET_PC[PC_MAX_B:2].
REQ-028 First cycle after reset release SHALL request RESET_PC; reset asserted mid-operation SHALL discard queue and in-flight data on that edge.

Verification
REQ-029 Reset release, no stall, DEPTH=4: addresses 0,1,2,... one per cycle; decodeValid=1 from the 2nd cycle after release, PCs 0,1,2 consecutive with matching mem data.
REQ-030 stall_fetch held 6 cycles: queueCount reaches 4, imemRequest drops to 0; on release PCs continue in order with no gap.
REQ-031 Redirect to word 0x040 with 3 entries queued: queueCount=0 next cycle, stale response dropped, PC 0x040 appears 2 cycles later, then 0x041.
REQ-032 Redirect with stall_fetch=1 and full queue: redirect wins, address 0x040 issued the same cycle.
REQ-033 RESET_PC=32'h0000FFFC, PC_MAX_B=15: PCs 0x3FFF then 0x0000.
REQ-034 reset pulsed while 2 entries queued and one in flight: all outputs return to REQ-027 values; fetch restarts at RESET_PC.
